// File: rtl/parking_occupancy_counter.sv
// Vehicle occupancy counter with edge-detected entry/exit sensors,
// saturation at capacity and sticky overflow/underflow flags.
module parking_occupancy_counter #(
  parameter int WIDTH       = 4,
  parameter int CAPACITY    = 10,
  parameter int ALMOST_FULL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] free_slots,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] AF  = WIDTH'(ALMOST_FULL);

  logic             up_q;
  logic             down_q;
  logic             up_ev;
  logic             down_ev;
  logic [WIDTH-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             overflow_ev;
  logic             underflow_ev;

  assign up_ev   = up & ~up_q;
  assign down_ev = down & ~down_q;

  // Simultaneous entry and exit cancel, so neither error can fire then.
  assign overflow_ev  = up_ev & ~down_ev & (count_q == CAP);
  assign underflow_ev = down_ev & ~up_ev & (count_q == '0);

  always_ff @(posedge clk) begin
    // Edge registers track the inputs even in reset so a held sensor
    // does not count on reset release.
    up_q   <= up;
    down_q <= down;
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (up_ev && !down_ev && count_q != CAP) begin
        count_q <= count_q + 1'b1;
      end else if (down_ev && !up_ev && count_q != '0) begin
        count_q <= count_q - 1'b1;
      end
      overflow_q  <= (overflow_q & ~clr_err) | overflow_ev;
      underflow_q <= (underflow_q & ~clr_err) | underflow_ev;
    end
  end

  assign count         = count_q;
  assign free_slots    = CAP - count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == CAP);
  assign almost_full   = (count_q >= AF);
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Scoreboard bench for parking_occupancy_counter: a behavioural model
// queues the expected state each cycle, compared one cycle later.
module tb_parking_occupancy_counter;

  localparam int WIDTH = 4;
  localparam int CAP   = 10;
  localparam int AFT   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             up = 1'b0;
  logic             down = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] free_slots;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow_err;
  logic             underflow_err;

  parking_occupancy_counter #(
    .WIDTH(WIDTH), .CAPACITY(CAP), .ALMOST_FULL(AFT)
  ) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .clr_err(clr_err),
    .count(count), .free_slots(free_slots), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    cnt;
    int    free;
    int    flags;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Behavioural model state
  bit m_upq = 0, m_dnq = 0, m_ovf = 0, m_unf = 0;
  int m_cnt = 0;

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input bit u, input bit d, input bit c, input bit r, input string tag);
    bit uev, dev, oe, ue;
    exp_t e, got;
    up = u; down = d; clr_err = c; reset = r;
    oe = 0; ue = 0;
    if (r) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else begin
      uev = u && !m_upq;
      dev = d && !m_dnq;
      if (uev && dev) begin
      end else if (uev) begin
        if (m_cnt < CAP) m_cnt++; else oe = 1;
      end else if (dev) begin
        if (m_cnt > 0) m_cnt--; else ue = 1;
      end
      if (c) begin m_ovf = 0; m_unf = 0; end
      if (oe) m_ovf = 1;
      if (ue) m_unf = 1;
    end
    m_upq = u; m_dnq = d;
    e.tag   = tag;
    e.cnt   = m_cnt;
    e.free  = CAP - m_cnt;
    e.flags = {27'd0, m_cnt == 0, m_cnt == CAP, m_cnt >= AFT, m_ovf, m_unf};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      got = exp_q.pop_front();
      check({got.tag, ".count"}, int'(count), got.cnt);
      check({got.tag, ".free"}, int'(free_slots), got.free);
      check({got.tag, ".flags{e,f,af,ov,un}"},
            int'({empty, full, almost_full, overflow_err, underflow_err}), got.flags);
      $display("%s: up=%0b down=%0b clr=%0b rst=%0b count=%0d free=%0d e=%0b f=%0b af=%0b ov=%0b un=%0b",
               got.tag, u, d, c, r, count, free_slots, empty, full, almost_full,
               overflow_err, underflow_err);
    end
  endtask

  task automatic pulse(input bit u, input bit d, input bit c, input string tag);
    cyc(u, d, c, 0, tag);
    cyc(0, 0, 0, 0, {tag, "_gap"});
  endtask

  initial begin
    cyc(0, 0, 0, 1, "reset0");
    cyc(0, 0, 0, 1, "reset1");
    check("reset.count", int'(count), 0);
    check("reset.free", int'(free_slots), CAP);

    for (int i = 0; i < CAP; i++) pulse(1, 0, 0, $sformatf("entry%0d", i + 1));
    check("full_at_cap", int'(full), 1);
    pulse(1, 0, 0, "overflow");
    check("overflow_set", int'(overflow_err), 1);
    pulse(0, 0, 1, "clr_err");
    check("overflow_cleared", int'(overflow_err), 0);

    pulse(1, 1, 0, "simul_full");
    for (int i = 0; i < CAP; i++) pulse(0, 1, 0, $sformatf("exit%0d", i + 1));
    pulse(1, 1, 0, "simul_empty");
    check("simul_empty_no_unf", int'(underflow_err), 0);

    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, "hold_down");
    cyc(0, 0, 0, 0, "release_down");
    check("underflow_set", int'(underflow_err), 1);
    pulse(0, 0, 1, "clr_unf");

    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, "hold_up");
    cyc(0, 0, 0, 0, "release_up");
    check("held_up_once", int'(count), 1);

    for (int i = 0; i < CAP - 1; i++) pulse(1, 0, 0, "refill");
    pulse(1, 0, 1, "clr_vs_set");
    check("clr_vs_set_ovf", int'(overflow_err), 1);
    for (int i = 0; i < 4; i++) pulse(0, 1, 0, "to_six");
    check("at_six", int'(count), 6);

    cyc(1, 0, 0, 0, "up_before_rst");
    cyc(1, 0, 0, 1, "rst_up_held0");
    cyc(1, 0, 0, 1, "rst_up_held1");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, "post_rst_held");
    check("no_inc_after_rst", int'(count), 0);
    cyc(0, 0, 0, 0, "up_fall");
    cyc(1, 0, 0, 0, "up_rise");
    cyc(0, 0, 0, 0, "idle");

    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(9) == 0), 0, "random");

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Parametrised occupancy counter for the parking-lot controller. It counts vehicles from the entry (`up`) and exit (`down`) sensor signals, using rising-edge detection so that a sensor held high counts once. The count saturates at a configurable capacity and never goes below zero. Status flags drive the lot display and the entry-barrier logic, and sticky error flags record entry attempts while full and exit events while empty.

## Interface

**Parameters**
- `WIDTH`, default 4: width of `count` and `free_slots`.
- `CAPACITY`, default 10: maximum occupancy.
  - Legal range is 1 ≤ `CAPACITY` ≤ 2^`WIDTH`−1.
- `ALMOST_FULL`, default 8: threshold for `almost_full`.
  - Legal range is 1 ≤ `ALMOST_FULL` ≤ `CAPACITY`.

**Ports**
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `up` input 1: entry sensor level; a vehicle enters on its rising edge.
- `down` input 1: exit sensor level; a vehicle leaves on its rising edge.
- `clr_err` input 1: clears the sticky error flags.
- `count` output `WIDTH`: current occupancy, 0..`CAPACITY`.
- `free_slots` output `WIDTH`: `CAPACITY` − `count`.
- `empty` output 1: `count` == 0.
- `full` output 1: `count` == `CAPACITY`.
- `almost_full` output 1: `count` ≥ `ALMOST_FULL`.
- `overflow_err` output 1: sticky; set by an entry event while full.
- `underflow_err` output 1: sticky; set by an exit event while empty.

## Operation

**Edge detection**
- Registers `up_q` and `down_q` hold the previous-cycle values of `up` and `down`.
- `up_ev` = `up` & ~`up_q`; `down_ev` = `down` & ~`down_q`.
- While `reset` is high, `up_q` and `down_q` load the live `up`/`down` values. A sensor held high through reset release therefore produces no event.

**Count update** (only when `reset` = 0; priority in the order listed)
- `up_ev` & `down_ev`: count unchanged, no error. One car in and one out in the same cycle is net zero, even when the lot is full or empty.
- `up_ev` only, `count` < `CAPACITY`: `count` + 1.
- `up_ev` only, `count` == `CAPACITY`: count unchanged; `overflow_err` ← 1.
- `down_ev` only, `count` > 0: `count` − 1.
- `down_ev` only, `count` == 0: count unchanged; `underflow_err` ← 1.
- No event: hold.

**Arithmetic**
- Unsigned, `WIDTH` bits.
- Saturation guarantees `count` never wraps and never exceeds `CAPACITY`.
- `free_slots` never underflows.

**Error flags**
- Once set, each flag holds until `clr_err` or `reset`.
- `clr_err` clears both flags at the next edge.
- If `clr_err` and a new error event occur in the same cycle, the flag is set: set wins.

**Status outputs**
- `empty`, `full`, `almost_full` and `free_slots` are combinational decodes of the `count` register only. They are glitch-free relative to `clk` and change in the same cycle as `count`.

## Timing

**Reset values**
- `count` = 0, `free_slots` = `CAPACITY`, `empty` = 1, `full` = 0.
- `almost_full` = 0 (since `ALMOST_FULL` ≥ 1).
- `overflow_err` = 0, `underflow_err` = 0.

**Reset behaviour**
- Reset is synchronous: it takes effect at the first rising edge with `reset` = 1.
- Reset mid-operation discards any event present in that cycle.

**Latency**
- An `up` rising transition sampled at edge k updates `count`, the status flags and the error flags immediately after edge k (1-cycle latency from the input change).

**Input constraints**
- Minimum pulse: `up`/`down` must be low for at least 1 cycle between events. A signal held high yields exactly one event.
- Inputs must already be synchronous to `clk`; debouncing and synchronisation are done upstream.

**Throughput**
- One entry event and one exit event per cycle, maximum.

## Test plan

- **Reset then entries:** reset, then 10 single-cycle `up` pulses spaced 2 cycles apart (`CAPACITY` = 10, `ALMOST_FULL` = 8).
  - Required: `count` steps 1..10; `almost_full` rises on `count` = 8; `full` = 1 and `free_slots` = 0 at 10.
- **Overflow while full:** one more `up` pulse while `full`.
  - Required: `count` stays 10 and `overflow_err` = 1.
  - Then pulse `clr_err`: `overflow_err` = 0 the next cycle.
- **Held level and underflow:** from empty, hold `down` high for 5 cycles.
  - Required: exactly one `underflow_err` set, `count` = 0.
  - Separately, hold `up` high for 20 cycles: `count` increments exactly once, to 1.
- **Simultaneous events:** at `count` = 10, pulse `up` and `down` in the same cycle.
  - Required: `count` = 10, no error.
  - Repeat at `count` = 0: `count` = 0, `underflow_err` stays 0.
- **Clear-versus-set and reset with held input:** assert `clr_err` in the same cycle as an overflow event → `overflow_err` = 1.
  - Then assert `reset` at `count` = 6 with `up` held high across reset release.
  - Required: after reset, `count` = 0, `empty` = 1, all errors 0, and no increment until `up` falls and rises again.
